// File: rtl/usart_sync_rx.sv
// ---------------------------------------------------------------------------
// usart_sync_rx
// Synchronous-mode (slave) USART receiver. Frames on rxd are sampled on the
// rising edge of the external serial clock xcki. Both pins are resynchronized
// into the clk domain. A completed frame goes into a single-entry receive
// buffer that the bus side pops with rd_en.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   xcki       external serial clock (async, period >= 8 clk)
//   rxd        serial data (async, stable around the xcki rising edge)
//   rx_en      receiver enable; dropping it mid-frame aborts the frame
//   rd_en      one-clk read strobe, pops the receive buffer
//   rx_data    buffered data, LSB aligned, unused upper bits read 0
//   rx_valid   receive buffer full
//   frame_err  a stop bit of the buffered frame was 0
//   parity_err parity mismatch on the buffered frame
//   overrun    a frame was dropped because the buffer was full
//   busy       frame reception in progress
// ---------------------------------------------------------------------------
module usart_sync_rx #(
  parameter int DATA_BITS  = 8,  // 5..8
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1   // 1 or 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       xcki,
  input  logic       rxd,
  input  logic       rx_en,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [DATA_BITS-1:0]   sh_q, sh_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   commit_q, commit_d;

  logic xck_s1, xck_s2, xck_d;
  logic rxd_s1, rxd_s2;
  logic strike;

  // Two-flop synchronizers plus an edge-detect flop on the serial clock.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xck_s1 <= 1'b0;
      xck_s2 <= 1'b0;
      xck_d  <= 1'b0;
      rxd_s1 <= 1'b0;
      rxd_s2 <= 1'b0;
    end else begin
      xck_s1 <= xcki;
      xck_s2 <= xck_s1;
      xck_d  <= xck_s2;
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  // One-clk pulse on the synchronized rising edge of xcki.
  assign strike = xck_s2 & ~xck_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    commit_d = 1'b0;

    if (!rx_en) begin
      // Abort: the partial frame is simply abandoned.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (strike) begin
      unique case (state_q)
        IDLE: begin
          if (!rxd_s2) begin
            state_d = DATA;
            cnt_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
        DATA: begin
          sh_d = {rxd_s2, sh_q[DATA_BITS-1:1]};  // LSB arrives first
          if (cnt_q == 3'(DATA_BITS - 1)) begin
            cnt_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        PARITY: begin
          perr_d  = ((^sh_q) ^ rxd_s2) != (PARITY_ODD != 0);
          state_d = STOP;
        end
        STOP: begin
          if (!rxd_s2) ferr_d = 1'b1;
          if (cnt_q == 3'(STOP_BITS - 1)) begin
            cnt_d    = '0;
            commit_d = 1'b1;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  // Receive buffer. A read in the commit cycle frees the slot, so the new
  // frame loads and no overrun is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit_q && (!rx_valid || rd_en)) begin
      rx_data    <= 8'(sh_q);
      rx_valid   <= 1'b1;
      frame_err  <= ferr_q;
      parity_err <= perr_q;
      if (rd_en) overrun <= 1'b0;
    end else if (commit_q) begin
      overrun <= 1'b1;
    end else if (rd_en && rx_valid) begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: doc/usart_sync_rx.md
Name: usart_sync_rx

Overview:
Synchronous-mode (slave) USART receiver. It deserializes frames on rxd, clocked by the external serial clock xcki, into an 8-bit receive buffer that the bus interface reads. It is the receiving end of the USART serial link and runs in the system clk domain. xcki and rxd are resynchronized internally.

Parameters:
DATA_BITS, 8, data bits per frame (5..8); unused upper rx_data bits read 0
PARITY_EN, 1, 1 = parity bit follows data
PARITY_ODD, 0, 0 = even parity, 1 = odd parity
STOP_BITS, 1, stop bits checked (1 or 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
xcki  input  1  external serial clock, async to clk, period >= 8 clk
rxd  input  1  serial data, async to clk, stable around xcki rising edge
rx_en  input  1  receiver enable
rd_en  input  1  bus read strobe, 1 clk pulse; pops the receive buffer
rx_data  output  8  received data, LSB aligned
rx_valid  output  1  receive buffer full (RXC)
frame_err  output  1  stop bit of buffered frame was 0
parity_err  output  1  parity mismatch on buffered frame
overrun  output  1  frame lost because the buffer was full
busy  output  1  frame reception in progress

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchronizers cleared to 0.
- xcki and rxd each pass through 2-flop synchronizers. A rising edge of synced xcki (sync=1, delayed=0) produces a one-clk sample strike. rxd is sampled on the strike, 3 clk after the pad edge.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on strike with rx_en=1 and rxd=0, go to DATA, set bit counter to 0, busy=1.
  - DATA: on each strike, shift rxd in LSB first. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
  - PARITY: on strike, store parity error = (XOR of data bits ^ rxd) != PARITY_ODD. Go to STOP.
  - STOP: sample STOP_BITS strikes. frame error = any stop sample equal to 0. After the last stop sample, commit the frame and return to IDLE; busy=0 in the same cycle.
- Commit, one clk after the final stop strike:
  - If rx_valid=0, or rd_en=1 in the commit cycle: load rx_data, frame_err and parity_err; rx_valid=1.
  - Otherwise: set overrun=1, discard the new frame, leave buffer contents unchanged.
- rd_en with rx_valid=1: next cycle rx_valid=0, frame_err=0, parity_err=0, overrun=0. rx_data holds its value.
- rd_en with rx_valid=0: ignored.
- Read and commit in the same cycle: the read is honoured, the new frame loads, rx_valid stays 1, no overrun.
- rx_en deasserted mid-frame: FSM returns to IDLE next clk, partial frame discarded, busy=0, buffer and flags unchanged.
- Frame error does not block the commit; the frame is stored with frame_err=1.
- After a frame error, the FSM requires only a new start bit (rxd=0 on a strike). No break detection.
- rst_n asserted mid-frame: immediate return to the reset state; no partial commit.

Test Plan:
1. clk period 2, xcki period 60, frame 0xA5, even parity bit 0, stop 1 -> rx_valid=1 within 3 clk after the stop edge; rx_data=0xA5, no errors; rd_en -> rx_valid=0.
2. Frame 0x3C with parity bit forced to 1 (even) -> parity_err=1 and rx_data=0x3C; clears after rd_en.
3. Frame 0x81 with stop bit 0 -> frame_err=1, rx_data=0x81. Next frame 0x7E -> received correctly after a read.
4. Two frames 0x11 then 0x22 with no read -> rx_data=0x11, overrun=1. rd_en in the 0x22 commit cycle instead -> rx_data=0x22, overrun=0.
5. rx_en dropped after 4 data bits, then raised; send 0x55 -> partial frame discarded, busy=0 within 1 clk; 0x55 received cleanly.
6. rst_n pulsed low during DATA bit 5 -> all outputs 0 asynchronously; subsequent frame 0xF0 received correctly.
